// File: rtl/gpio_bank_pkg.sv
// -----------------------------------------------------------------------------
// gpio_bank_pkg
//
// Shared definitions for the GPIO bank:
//   - register offsets within a channel's 8-entry window
//   - bit positions inside the CFG register
//   - a width-parametrised signed/unsigned "greater or equal" helper
// -----------------------------------------------------------------------------
package gpio_bank_pkg;

  // Register offsets inside one channel (address = {ch, offset[2:0]}).
  localparam int unsigned REG_OUT = 0;
  localparam int unsigned REG_DIR = 1;
  localparam int unsigned REG_IN  = 2;
  localparam int unsigned REG_THR = 3;
  localparam int unsigned REG_CFG = 4;

  // CFG bit positions.
  localparam int unsigned CFG_SIGNED = 0;
  localparam int unsigned CFG_IRQEN  = 1;
  localparam int unsigned CFG_PEND   = 2;

  // Widest channel the compare helper supports.
  localparam int unsigned CMP_MAX_W = 64;

  // a >= b over the low w bits of both operands (upper bits must be zero).
  // For a signed compare the sign bit of each operand is inverted, which
  // maps two's-complement order onto unsigned order, so one unsigned
  // comparator serves both modes at the full channel width.
  function automatic logic ge_cmp(
    input logic [CMP_MAX_W-1:0] a,
    input logic [CMP_MAX_W-1:0] b,
    input int unsigned          w,
    input logic                 signed_mode
  );
    logic [CMP_MAX_W-1:0] flip;
    flip = {{(CMP_MAX_W-1){1'b0}}, signed_mode} << (w - 32'd1);
    return ((a ^ flip) >= (b ^ flip));
  endfunction

endpackage : gpio_bank_pkg

// File: rtl/gpio_chan.sv
// -----------------------------------------------------------------------------
// gpio_chan
//
// One GPIO channel: OUT/DIR/THR/CFG registers, 2-flop pad synchroniser,
// signed/unsigned threshold compare, rising-crossing detector with a sticky
// pending flag, and per-bit tri-state pad drive.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   wr_en_i    write strobe, already qualified for this channel
//   wr_off_i   register offset of the write
//   wr_data_i  write data
//   rd_off_i   register offset of the read (combinational read word)
//   rd_word_o  read word for rd_off_i, 0 for unmapped offsets
//   pend_o     sticky interrupt pending flag
//   irq_en_o   interrupt enable bit from CFG
//   pad_io     the channel's W pads
// -----------------------------------------------------------------------------
module gpio_chan
  import gpio_bank_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en_i,
  input  logic [2:0]   wr_off_i,
  input  logic [W-1:0] wr_data_i,
  input  logic [2:0]   rd_off_i,
  output logic [W-1:0] rd_word_o,
  output logic         pend_o,
  output logic         irq_en_o,
  inout  wire  [W-1:0] pad_io
);

  // Architectural registers.
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] dir_q, dir_d;
  logic [W-1:0] thr_q, thr_d;
  logic         signed_q, signed_d;
  logic         irq_en_q, irq_en_d;
  logic         pend_q, pend_d;

  // Input path and edge detector state.
  logic [W-1:0] sync1_q, sync2_q;
  logic         cmp_q, cmp_d;

  // Decoded writes.
  logic wr_out, wr_dir, wr_thr, wr_cfg;
  logic cmp, rise, w1c, rearm;

  assign wr_out = wr_en_i && (wr_off_i == 3'(REG_OUT));
  assign wr_dir = wr_en_i && (wr_off_i == 3'(REG_DIR));
  assign wr_thr = wr_en_i && (wr_off_i == 3'(REG_THR));
  assign wr_cfg = wr_en_i && (wr_off_i == 3'(REG_CFG));

  // Threshold compare on the synchronised input, full channel width.
  assign cmp  = ge_cmp(CMP_MAX_W'(sync2_q), CMP_MAX_W'(thr_q), W, signed_q);
  assign rise = cmp & ~cmp_q;
  assign w1c  = wr_cfg & wr_data_i[CFG_PEND];

  // Changing what "above threshold" means must not look like a crossing:
  // pretend we were already above, so only a later genuine rise can fire.
  assign rearm = wr_thr | (wr_cfg & (wr_data_i[CFG_SIGNED] != signed_q));

  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    thr_d    = thr_q;
    signed_d = signed_q;
    irq_en_d = irq_en_q;

    if (wr_out) out_d = wr_data_i;
    if (wr_dir) dir_d = wr_data_i;
    if (wr_thr) thr_d = wr_data_i;
    if (wr_cfg) begin
      signed_d = wr_data_i[CFG_SIGNED];
      irq_en_d = wr_data_i[CFG_IRQEN];
    end

    // A new crossing beats a same-cycle clear.
    pend_d = rise | (pend_q & ~w1c);
    cmp_d  = rearm | cmp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      dir_q    <= '0;
      thr_q    <= '0;
      signed_q <= 1'b0;
      irq_en_q <= 1'b0;
      pend_q   <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      // Start "above" so THR=0 (always true) cannot raise pend after reset.
      cmp_q    <= 1'b1;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      thr_q    <= thr_d;
      signed_q <= signed_d;
      irq_en_q <= irq_en_d;
      pend_q   <= pend_d;
      sync1_q  <= pad_io;
      sync2_q  <= sync1_q;
      cmp_q    <= cmp_d;
    end
  end

  // Per-bit tri-state drive straight from the registers.
  for (genvar gi = 0; gi < W; gi++) begin : g_pad
    assign pad_io[gi] = dir_q[gi] ? out_q[gi] : 1'bz;
  end

  // Combinational read word; the top registers it.
  always_comb begin
    rd_word_o = '0;
    case (rd_off_i)
      3'(REG_OUT): rd_word_o = out_q;
      3'(REG_DIR): rd_word_o = dir_q;
      3'(REG_IN):  rd_word_o = sync2_q;
      3'(REG_THR): rd_word_o = thr_q;
      3'(REG_CFG): begin
        rd_word_o[CFG_SIGNED] = signed_q;
        rd_word_o[CFG_IRQEN]  = irq_en_q;
        rd_word_o[CFG_PEND]   = pend_q;
      end
      default:     rd_word_o = '0;
    endcase
  end

  assign pend_o   = pend_q;
  assign irq_en_o = irq_en_q;

endmodule : gpio_chan

// File: rtl/gpio_bank.sv
// -----------------------------------------------------------------------------
// gpio_bank
//
// Bank of N_CH GPIO channels of W bits each, between the register bus and
// the pads. Address = {channel, offset[2:0]}; channels outside N_CH and
// offsets 5-7 ignore writes and read as zero.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   wr_en     register write strobe
//   wr_addr   write address {ch, reg[2:0]}
//   wr_data   write data
//   rd_en     register read strobe
//   rd_addr   read address {ch, reg[2:0]}
//   rd_data   registered read data, holds when rd_valid=0
//   rd_valid  one-cycle pulse per accepted read
//   pad       pins, channel c on pad[c*W +: W]
//   irq       registered OR of enabled pending interrupts
//   irq_vec   registered per-channel pend & irq_en
// -----------------------------------------------------------------------------
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 5,
  parameter int unsigned AW   = $clog2(N_CH) + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [W-1:0]      rd_data,
  output logic              rd_valid,
  inout  wire  [N_CH*W-1:0] pad,
  output logic              irq,
  output logic [N_CH-1:0]   irq_vec
);

  // Channel fields of the addresses. Shifting rather than slicing keeps
  // the single-channel case (no channel bits at all) legal.
  logic [AW-1:0] wr_ch;
  logic [AW-1:0] rd_ch;

  assign wr_ch = wr_addr >> 3;
  assign rd_ch = rd_addr >> 3;

  logic [W-1:0]    chan_rd [N_CH];
  logic [N_CH-1:0] pend_vec;
  logic [N_CH-1:0] irq_en_vec;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    logic wr_hit;
    assign wr_hit = wr_en && (wr_ch == AW'(gi));

    gpio_chan #(
      .W (W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_hit),
      .wr_off_i  (wr_addr[2:0]),
      .wr_data_i (wr_data),
      .rd_off_i  (rd_addr[2:0]),
      .rd_word_o (chan_rd[gi]),
      .pend_o    (pend_vec[gi]),
      .irq_en_o  (irq_en_vec[gi]),
      .pad_io    (pad[gi*W +: W])
    );
  end

  // Read mux; an out-of-range channel matches nothing and reads zero.
  logic [W-1:0] rd_word;
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      if (rd_ch == AW'(c)) rd_word = chan_rd[c];
    end
  end

  logic [W-1:0]    rd_data_q, rd_data_d;
  logic            rd_valid_q;
  logic            irq_q;
  logic [N_CH-1:0] irq_vec_q;

  // Reads sample the registers before any same-cycle write lands.
  assign rd_data_d = rd_en ? rd_word : rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
      irq_vec_q  <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      irq_vec_q  <= pend_vec & irq_en_vec;
      irq_q      <= |(pend_vec & irq_en_vec);
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;
  assign irq_vec  = irq_vec_q;

endmodule : gpio_bank

// File: tb/tb_gpio_bank.sv
// -----------------------------------------------------------------------------
// tb_gpio_bank
//
// Directed checks of the documented scenarios followed by random register
// traffic and pad activity, all compared cycle by cycle with a reference
// model that tracks the programmer-visible state using integer arithmetic.
// -----------------------------------------------------------------------------
module tb_gpio_bank;
  import gpio_bank_pkg::*;

  localparam int N_CH = 4;
  localparam int W    = 5;
  localparam int AW   = 5;
  localparam int PW   = N_CH * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  wire  [PW-1:0] pad;
  logic          irq;
  logic [N_CH-1:0] irq_vec;

  // External pad drivers; enabled only on bits the DUT is not driving.
  logic [PW-1:0] ext_val;
  logic [PW-1:0] ext_en;

  for (genvar gi = 0; gi < PW; gi++) begin : g_ext
    assign pad[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
  end

  gpio_bank #(
    .N_CH (N_CH),
    .W    (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .pad      (pad),
    .irq      (irq),
    .irq_vec  (irq_vec)
  );

  // ---------------- reference model ----------------
  int out_m [N_CH];
  int dir_m [N_CH];
  int thr_m [N_CH];
  int seen1_m [N_CH];   // pad value one edge ago
  int seen2_m [N_CH];   // pad value two edges ago (what IN shows)
  bit sgn_m [N_CH];
  bit ien_m [N_CH];
  bit pend_m [N_CH];
  bit above_m [N_CH];   // previous "input >= threshold" verdict

  int exp_rd_data;
  bit exp_rd_valid;
  bit exp_irq;
  int exp_irq_vec;

  int checks   = 0;
  int failures = 0;

  // Numeric value of a W-bit field in the chosen interpretation.
  function automatic int as_num(int v, bit sgn);
    if (sgn && v >= (1 << (W - 1))) return v - (1 << W);
    return v;
  endfunction

  function automatic int model_read(int addr);
    int ch  = addr / 8;
    int off = addr % 8;
    if (ch >= N_CH) return 0;
    case (off)
      0: return out_m[ch];
      1: return dir_m[ch];
      2: return seen2_m[ch];
      3: return thr_m[ch];
      4: return (int'(pend_m[ch]) << 2) | (int'(ien_m[ch]) << 1) | int'(sgn_m[ch]);
      default: return 0;
    endcase
  endfunction

  function automatic int pad_level(int c);
    int p = 0;
    for (int b = 0; b < W; b++) begin
      if (dir_m[c][b]) p |= out_m[c] & (1 << b);
      else if (ext_val[c*W + b]) p |= (1 << b);
    end
    return p;
  endfunction

  // Advance the model across one clock edge using the inputs held now.
  task automatic model_step();
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        out_m[c] = 0; dir_m[c] = 0; thr_m[c] = 0;
        seen1_m[c] = 0; seen2_m[c] = 0;
        sgn_m[c] = 0; ien_m[c] = 0; pend_m[c] = 0;
        above_m[c] = 1;
      end
      exp_rd_data  = 0;
      exp_rd_valid = 0;
      exp_irq      = 0;
      exp_irq_vec  = 0;
      return;
    end
    exp_rd_valid = rd_en;
    if (rd_en) exp_rd_data = model_read(int'(rd_addr));
    exp_irq_vec = 0;
    for (int c = 0; c < N_CH; c++)
      if (pend_m[c] && ien_m[c]) exp_irq_vec |= (1 << c);
    exp_irq = (exp_irq_vec != 0);
    for (int c = 0; c < N_CH; c++) begin
      int  p     = pad_level(c);
      bit  above = as_num(seen2_m[c], sgn_m[c]) >= as_num(thr_m[c], sgn_m[c]);
      bit  hit   = wr_en && (int'(wr_addr) / 8 == c);
      int  off   = int'(wr_addr) % 8;
      bit  clear = hit && off == 4 && wr_data[2];
      bit  rearm = hit && (off == 3 || (off == 4 && wr_data[0] != sgn_m[c]));
      pend_m[c]  = (above && !above_m[c]) || (pend_m[c] && !clear);
      above_m[c] = rearm ? 1'b1 : above;
      seen2_m[c] = seen1_m[c];
      seen1_m[c] = p;
      if (hit) begin
        case (off)
          0: out_m[c] = int'(wr_data);
          1: dir_m[c] = int'(wr_data);
          3: thr_m[c] = int'(wr_data);
          4: begin sgn_m[c] = wr_data[0]; ien_m[c] = wr_data[1]; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs are checked 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < N_CH; c++)
      for (int b = 0; b < W; b++)
        ext_en[c*W + b] = !dir_m[c][b];
    chk("rd_valid", 32'(rd_valid), 32'(exp_rd_valid));
    chk("rd_data", 32'(rd_data), 32'(exp_rd_data));
    chk("irq", 32'(irq), 32'(exp_irq));
    chk("irq_vec", 32'(irq_vec), 32'(exp_irq_vec));
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wr(int ch, int off, logic [W-1:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(ch * 8 + off);
    wr_data = data;
    cycle();
  endtask

  task automatic rd_chk(string tag, int ch, int off, logic [W-1:0] exp);
    rd_en   = 1'b1;
    rd_addr = AW'(ch * 8 + off);
    cycle();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic idle(int n);
    repeat (n) cycle();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    ext_val = '0; ext_en = '1;
    cycle();
    rst = 1'b1;
    cycle();

    // Every register of every channel reads zero after reset.
    for (int a = 0; a < 32; a++) rd_chk("reset_read", a / 8, a % 8, '0);

    // THR=0 is always met, yet no interrupt may appear.
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("irq_idle", 32'(irq), 32'd0);
    end

    // All pads released: the external pattern shows through unchanged.
    ext_val = 20'h5A5A5;
    cycle();
    chk("pads_released", 32'(pad), 32'h5A5A5);

    // ch1: drive bits 4,2,0 high, bits 3,1 from outside.
    wr(1, 1, 5'b10101);
    wr(1, 0, 5'b11111);
    ext_val[9:5] = 5'b01000;
    cycle();
    chk("pad_ch1_mix", 32'(pad[9:5]), 32'b11101);
    cycle();
    rd_chk("in_ch1", 1, 2, 5'b11101);

    // ch2 signed: -16 then +3 against -4.
    ext_val[14:10] = 5'b10000;
    wr(2, 3, 5'b11100);
    wr(2, 4, 5'b00011);
    idle(4);
    ext_val[14:10] = 5'b00011;
    cycle(); chk("sgn_e1_irq", 32'(irq), 32'd0);
    cycle(); chk("sgn_e2_irq", 32'(irq), 32'd0);
    cycle(); chk("sgn_e3_irq", 32'(irq), 32'd0);
    rd_en = 1'b1; rd_addr = AW'(2 * 8 + 4);
    cycle();
    chk("sgn_e4_irq", 32'(irq), 32'd1);
    chk("sgn_e4_vec", 32'(irq_vec), 32'b0100);
    chk("sgn_e3_pend", 32'(rd_data), 32'b00111);

    // ch2 unsigned, clearing pend: 16 and 3 are below 28, 30 is not.
    wr(2, 4, 5'b00110);
    ext_val[14:10] = 5'b10000;
    idle(4);
    ext_val[14:10] = 5'b00011;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("uns_below_irq", 32'(irq), 32'd0);
    end
    ext_val[14:10] = 5'b11110;
    idle(3);
    chk("uns_e3_irq", 32'(irq), 32'd0);
    cycle();
    chk("uns_e4_irq", 32'(irq), 32'd1);

    // Set wins over a same-cycle W1C.
    ext_val[14:10] = 5'b00000;
    idle(5);
    ext_val[14:10] = 5'b11111;
    idle(2);
    wr(2, 4, 5'b00110);
    cycle();
    chk("set_wins_irq", 32'(irq), 32'd1);
    rd_chk("set_wins_cfg", 2, 4, 5'b00110);

    // Plain W1C: pend clears, irq follows one cycle later.
    wr(2, 4, 5'b00110);
    chk("w1c_irq_lag", 32'(irq), 32'd1);
    cycle();
    chk("w1c_irq_drop", 32'(irq), 32'd0);
    chk("w1c_vec_drop", 32'(irq_vec), 32'd0);

    // Same-cycle read and write of one address returns the old value.
    wr_en = 1'b1; wr_addr = AW'(0); wr_data = 5'b10101;
    rd_en = 1'b1; rd_addr = AW'(0);
    cycle();
    chk("rw_same_old", 32'(rd_data), 32'd0);
    rd_chk("rw_same_new", 0, 0, 5'b10101);

    // Unmapped offsets.
    wr(0, 6, 5'b11111);
    rd_chk("off6_zero", 0, 6, '0);
    rd_chk("off5_zero", 0, 5, '0);
    rd_chk("off7_zero", 3, 7, '0);

    // Reset drops an in-flight read.
    rd_en = 1'b1; rd_addr = AW'(0); rst = 1'b1;
    cycle();
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        wr_en   = 1'b1;
        wr_addr = AW'($urandom);
        wr_data = W'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        rd_en   = 1'b1;
        rd_addr = AW'($urandom);
      end
      if ($urandom_range(0, 5) == 0) ext_val = PW'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gpio_bank
